// File: rtl/ppm16_modulator.sv
// 16-ary pulse-position modulator: one 4-bit symbol per 16-chip frame, a single
// pulse in the chip selected by the symbol, optional idle guard chips between frames.
module ppm16_modulator #(
  parameter int CHIPS_PER_SLOT = 2,
  parameter int PULSE_WIDTH    = 1,
  parameter int GUARD_CHIPS    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [3:0]  symbol_in,
  input  logic        symbol_valid,
  output logic        symbol_ready,
  output logic        pulse_out,
  output logic        frame_start,
  output logic [3:0]  chip_idx,
  output logic        busy,
  output logic        underrun,
  output logic [15:0] frame_count
);

  // state | meaning
  // IDLE  | no frame in progress, waiting for a held symbol and enable
  // FRAME | emitting 16 chips of the active symbol
  // GUARD | idle guard chips after a frame, pulse suppressed
  typedef enum logic [1:0] {IDLE, FRAME, GUARD} state_t;

  localparam logic [7:0]  CYC_LAST   = 8'(CHIPS_PER_SLOT - 1);
  localparam logic [7:0]  PW_C       = 8'(PULSE_WIDTH);
  localparam int          GUARD_CYC  = GUARD_CHIPS * CHIPS_PER_SLOT;
  localparam logic [11:0] GUARD_LOAD = (GUARD_CYC > 0) ? 12'(GUARD_CYC - 1) : 12'd0;
  localparam bit          HAS_GUARD  = (GUARD_CHIPS > 0);

  state_t      state_q, state_d;
  logic        hold_vld_q, hold_vld_d;
  logic [3:0]  hold_sym_q, hold_sym_d;
  logic [3:0]  cur_sym_q, cur_sym_d;
  logic [3:0]  chip_q, chip_d;
  logic [7:0]  cyc_q, cyc_d;
  logic [11:0] guard_q, guard_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        underrun_q, underrun_d;
  logic        accept;
  logic        start_ok;
  logic        seq_end;

  assign symbol_ready = enable & ~hold_vld_q;
  assign accept       = symbol_valid & symbol_ready;
  assign start_ok     = hold_vld_q & enable;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      hold_vld_q    <= 1'b0;
      hold_sym_q    <= 4'd0;
      cur_sym_q     <= 4'd0;
      chip_q        <= 4'd0;
      cyc_q         <= 8'd0;
      guard_q       <= 12'd0;
      frame_count_q <= 16'd0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_vld_q    <= hold_vld_d;
      hold_sym_q    <= hold_sym_d;
      cur_sym_q     <= cur_sym_d;
      chip_q        <= chip_d;
      cyc_q         <= cyc_d;
      guard_q       <= guard_d;
      frame_count_q <= frame_count_d;
      underrun_q    <= underrun_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    hold_vld_d    = hold_vld_q;
    hold_sym_d    = hold_sym_q;
    cur_sym_d     = cur_sym_q;
    chip_d        = chip_q;
    cyc_d         = cyc_q;
    guard_d       = guard_q;
    frame_count_d = frame_count_q;
    underrun_d    = 1'b0;
    seq_end       = 1'b0;

    if (accept) begin
      hold_vld_d = 1'b1;
      hold_sym_d = symbol_in;
    end

    unique case (state_q)
      IDLE: begin
      end
      FRAME: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d  = 8'd0;
          chip_d = chip_q + 4'd1;
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
        if ((cyc_q == CYC_LAST) && (chip_q == 4'd15)) begin
          frame_count_d = frame_count_q + 16'd1;
          if (HAS_GUARD) begin
            state_d = GUARD;
            guard_d = GUARD_LOAD;
            chip_d  = 4'd0;
            cyc_d   = 8'd0;
          end else begin
            seq_end = 1'b1;
          end
        end
      end
      GUARD: begin
        if (guard_q == 12'd0) seq_end = 1'b1;
        else                  guard_d = guard_q - 12'd1;
      end
      default: state_d = IDLE;
    endcase

    // Frame/guard end and IDLE share one reload path so back-to-back frames have no gap.
    if (((state_q == IDLE) || seq_end) && start_ok) begin
      state_d    = FRAME;
      cur_sym_d  = hold_sym_q;
      hold_vld_d = 1'b0;
      chip_d     = 4'd0;
      cyc_d      = 8'd0;
    end else if (seq_end) begin
      state_d    = IDLE;
      chip_d     = 4'd0;
      cyc_d      = 8'd0;
      underrun_d = enable;
    end
  end

  assign pulse_out   = (state_q == FRAME) && (chip_q == cur_sym_q) && (cyc_q < PW_C);
  assign frame_start = (state_q == FRAME) && (chip_q == 4'd0) && (cyc_q == 8'd0);
  assign chip_idx    = chip_q;
  assign busy        = (state_q != IDLE);
  assign underrun    = underrun_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_ppm16_modulator.sv
// Directed bench for ppm16_modulator: accepted symbols go into a scoreboard queue
// and are popped at each frame_start to check pulse position and chip index.
module tb_ppm16_modulator;
  localparam int CPS = 2;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [3:0]  symbol_in;
  logic        symbol_valid;
  logic        sel;

  logic        ready0, pulse0, fs0, busy0, under0;
  logic [3:0]  chip0;
  logic [15:0] fcnt0;
  logic        ready1, pulse1, fs1, busy1, under1;
  logic [3:0]  chip1;
  logic [15:0] fcnt1;

  logic        m_ready, m_pulse, m_fs, m_busy, m_under;
  logic [3:0]  m_chip;
  logic [15:0] m_fcnt;

  int n_assert = 0;
  int n_fail   = 0;
  int n_cycle  = 0;
  int n_pulse, n_busy, n_underrun, n_fs;
  int fs_cycle, cur_exp, saved;
  bit in_frame;
  int exp_q[$];
  int fs_times[$];

  ppm16_modulator #(.CHIPS_PER_SLOT(CPS), .PULSE_WIDTH(1), .GUARD_CHIPS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .symbol_in(symbol_in),
    .symbol_valid(symbol_valid), .symbol_ready(ready0), .pulse_out(pulse0),
    .frame_start(fs0), .chip_idx(chip0), .busy(busy0), .underrun(under0),
    .frame_count(fcnt0));

  ppm16_modulator #(.CHIPS_PER_SLOT(CPS), .PULSE_WIDTH(1), .GUARD_CHIPS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .symbol_in(symbol_in),
    .symbol_valid(symbol_valid), .symbol_ready(ready1), .pulse_out(pulse1),
    .frame_start(fs1), .chip_idx(chip1), .busy(busy1), .underrun(under1),
    .frame_count(fcnt1));

  assign m_ready = sel ? ready1 : ready0;
  assign m_pulse = sel ? pulse1 : pulse0;
  assign m_fs    = sel ? fs1    : fs0;
  assign m_busy  = sel ? busy1  : busy0;
  assign m_under = sel ? under1 : under0;
  assign m_chip  = sel ? chip1  : chip0;
  assign m_fcnt  = sel ? fcnt1  : fcnt0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic monitor();
    n_cycle++;
    if (m_busy)  n_busy++;
    if (m_under) n_underrun++;
    if (m_fs) begin
      n_fs++;
      fs_times.push_back(n_cycle);
      chk("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) cur_exp = exp_q.pop_front();
      else                   cur_exp = -1;
      fs_cycle = n_cycle;
      in_frame = 1'b1;
    end
    if (m_pulse) begin
      n_pulse++;
      chk("pulse_in_frame", in_frame, 1);
      chk("pulse_offset", n_cycle - fs_cycle, cur_exp * CPS);
      chk("pulse_chip", m_chip, cur_exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    symbol_valid = 1'b0;
    symbol_in = 4'd0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    fs_times.delete();
    n_pulse = 0; n_busy = 0; n_underrun = 0; n_fs = 0;
    in_frame = 1'b0;
  endtask

  task automatic send(input logic [3:0] s);
    symbol_in = s;
    symbol_valid = 1'b1;
    for (int k = 0; k < 200 && !m_ready; k++) tick();
    chk("send_ready", m_ready, 1);
    if (m_ready) begin
      exp_q.push_back(int'(s));
      tick();
    end
    symbol_valid = 1'b0;
  endtask

  task automatic wait_chip(input logic [3:0] c);
    for (int k = 0; k < 200 && m_chip != c; k++) tick();
    chk("wait_chip", m_chip, c);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300 && m_busy; k++) tick();
    chk("wait_idle", m_busy, 0);
  endtask

  function automatic int fs_gap();
    if (fs_times.size() < 2) return -1;
    return fs_times[1] - fs_times[0];
  endfunction

  initial begin
    rst_n = 1'b0; enable = 1'b0; symbol_in = 4'd0; symbol_valid = 1'b0; sel = 1'b0;

    // reset values
    do_reset();
    chk("rst_pulse", m_pulse, 0);
    chk("rst_fs", m_fs, 0);
    chk("rst_chip", m_chip, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_underrun", m_under, 0);
    chk("rst_fcount", m_fcnt, 0);
    chk("rst_ready_en0", m_ready, 0);
    enable = 1'b1;
    #1;
    chk("rst_ready_en1", m_ready, 1);

    // single symbol 5
    send(4'd5);
    chk("t1_fs_not_yet", m_fs, 0);
    tick();
    chk("t1_fs_latency", m_fs, 1);
    repeat (40) tick();
    chk("t1_pulses", n_pulse, 1);
    chk("t1_busy_cycles", n_busy, 32);
    chk("t1_fcount", m_fcnt, 1);
    chk("t1_underrun", n_underrun, 1);
    chk("t1_frames", n_fs, 1);
    chk("t1_sb_empty", exp_q.size(), 0);

    // back-to-back symbols 0 then 15
    do_reset();
    send(4'd0);
    chk("t2_ready_held", m_ready, 0);
    send(4'd15);
    chk("t2_ready_held2", m_ready, 0);
    repeat (40) tick();
    chk("t2_no_early_underrun", n_underrun, 0);
    repeat (30) tick();
    chk("t2_frames", n_fs, 2);
    chk("t2_gap", fs_gap(), 32);
    chk("t2_busy_cycles", n_busy, 64);
    chk("t2_pulses", n_pulse, 2);
    chk("t2_underrun", n_underrun, 1);
    chk("t2_fcount", m_fcnt, 2);

    // guard chips = 2, symbols 3 and 3
    sel = 1'b1;
    do_reset();
    send(4'd3);
    send(4'd3);
    repeat (90) tick();
    chk("t3_frames", n_fs, 2);
    chk("t3_gap", fs_gap(), 36);
    chk("t3_pulses", n_pulse, 2);
    chk("t3_busy_cycles", n_busy, 72);
    chk("t3_fcount", m_fcnt, 2);
    chk("t3_underrun", n_underrun, 1);
    sel = 1'b0;

    // enable dropped at chip 4 with symbol 9 held
    do_reset();
    send(4'd2);
    send(4'd9);
    wait_chip(4'd4);
    enable = 1'b0;
    wait_idle();
    chk("t4_fcount_1", m_fcnt, 1);
    chk("t4_no_underrun", n_underrun, 0);
    repeat (5) tick();
    chk("t4_stays_idle", n_fs, 1);
    chk("t4_busy_idle", m_busy, 0);
    enable = 1'b1;
    tick();
    chk("t4_restart_fs", m_fs, 1);
    repeat (40) tick();
    chk("t4_pulses", n_pulse, 2);
    chk("t4_fcount_2", m_fcnt, 2);
    chk("t4_underrun", n_underrun, 1);

    // reset during chip 7 of a symbol-7 frame, with symbol 4 held
    do_reset();
    send(4'd7);
    send(4'd4);
    wait_chip(4'd7);
    chk("t5_pulse_before", m_pulse, 1);
    rst_n = 1'b0;
    tick();
    chk("t5_pulse", m_pulse, 0);
    chk("t5_fs", m_fs, 0);
    chk("t5_chip", m_chip, 0);
    chk("t5_busy", m_busy, 0);
    chk("t5_underrun", m_under, 0);
    chk("t5_fcount", m_fcnt, 0);
    chk("t5_ready", m_ready, 1);
    rst_n = 1'b1;
    exp_q.delete();
    in_frame = 1'b0;
    saved = n_fs;
    repeat (40) tick();
    chk("t5_held_discarded", n_fs, saved);
    chk("t5_fcount_after", m_fcnt, 0);

    // frame_count wrap from a preloaded 0xFFFF
    do_reset();
    force dut0.frame_count_q = 16'hFFFF;
    tick();
    release dut0.frame_count_q;
    tick();
    chk("t6_preload", m_fcnt, 16'hFFFF);
    send(4'd1);
    repeat (40) tick();
    chk("t6_wrap", m_fcnt, 0);
    chk("t6_pulses", n_pulse, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
